// File: rtl/sb_rx_msg_queue.sv
// Receive-side sideband message queue: buffers decoded {message, payload} entries and serves one per request.
// Optional duplicate-resend filter is built when SB_RX_DUP_FILTER_EN is defined.

package sb_rx_pkg;
   localparam logic [3:0] SB_NONE             = 4'd0;
   localparam logic [3:0] SBINIT_out_of_reset = 4'd1;
   localparam logic [3:0] SBINIT_done_req     = 4'd2;
   localparam logic [3:0] SBINIT_done_resp    = 4'd3;
   localparam logic [3:0] MBINIT_param_req    = 4'd4;
   localparam logic [3:0] MBINIT_param_resp   = 4'd5;

   typedef struct packed {
      logic [4:0]  opcode;
      logic [3:0]  msg_num;
      logic [15:0] msg_info;
   } SB_msg_t;

   function automatic SB_msg_t reset_SB_msg();
      SB_msg_t m;
      m = '0;
      return m;
   endfunction
endpackage

module sb_rx_msg_queue
   import sb_rx_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int DROP_CNT_W = 8
) (
   input  logic                         clk_100MHz,
   input  logic                         reset_n,
   input  logic                         enable_i,
   input  logic                         flush_i,
   input  SB_msg_t                      rx_msg_i,
   input  logic [63:0]                  rx_data_i,
   input  logic                         rx_msg_valid_i,
   input  logic                         SB_RX_msg_req_i,
   output SB_msg_t                      SB_RX_msg_o,
   output logic [63:0]                  SB_RX_dataBus_o,
   output logic                         SB_RX_msg_valid_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o,
   output logic                         overflow_o,
   output logic [DROP_CNT_W-1:0]        drop_count_o
);
   localparam int LVL_W   = $clog2(DEPTH + 1);
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int MSG_W   = $bits(SB_msg_t);
   localparam int ENTRY_W = MSG_W + 64;

   logic [ENTRY_W-1:0]    mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
   logic [LVL_W-1:0]      level_reg;
   logic                  pending_reg;
   logic                  valid_reg;
   SB_msg_t               msg_reg;
   logic [63:0]           data_reg;
   logic                  overflow_reg;
   logic [DROP_CNT_W-1:0] drop_reg;

   logic [ENTRY_W-1:0]    in_entry;
   logic [ENTRY_W-1:0]    head_entry;
   logic                  push_req, pop, full, dup, push, drop_full, drop;

   assign in_entry   = {rx_msg_i, rx_data_i};
   assign head_entry = mem[rd_ptr_reg];
   assign push_req   = rx_msg_valid_i && enable_i && !flush_i;
   assign pop        = pending_reg && (level_reg != '0) && enable_i && !flush_i;
   assign full       = (level_reg == LVL_W'(DEPTH));
   // A full queue still accepts when the head leaves in the same cycle.
   assign push       = push_req && !dup && (!full || pop);
   assign drop_full  = push_req && !dup && full && !pop;
   assign drop       = drop_full || (push_req && dup);

`ifdef SB_RX_DUP_FILTER_EN
   logic [ENTRY_W-1:0] hist_reg;
   logic               hist_valid_reg;

   assign dup = hist_valid_reg && (in_entry == hist_reg);

   always_ff @(posedge clk_100MHz) begin
      if (!reset_n) begin
         hist_reg       <= '0;
         hist_valid_reg <= 1'b0;
      end else if (flush_i) begin
         hist_valid_reg <= 1'b0;
      end else if (push) begin
         hist_reg       <= in_entry;
         hist_valid_reg <= 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   always_ff @(posedge clk_100MHz) begin
      if (push)
         mem[wr_ptr_reg] <= in_entry;
   end

   always_ff @(posedge clk_100MHz) begin
      if (!reset_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         pending_reg  <= 1'b0;
         valid_reg    <= 1'b0;
         msg_reg      <= reset_SB_msg();
         data_reg     <= '0;
         overflow_reg <= 1'b0;
         drop_reg     <= '0;
      end else begin
         if (flush_i) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            pending_reg <= 1'b0;
         end else begin
            if (push)
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
               level_reg <= level_reg + 1'b1;
            else if (pop && !push)
               level_reg <= level_reg - 1'b1;
            // A request landing on the delivering edge merges into the one being served.
            if (pop)
               pending_reg <= 1'b0;
            else if (enable_i && SB_RX_msg_req_i)
               pending_reg <= 1'b1;
         end
         valid_reg <= pop;
         if (pop) begin
            msg_reg  <= SB_msg_t'(head_entry[ENTRY_W-1:64]);
            data_reg <= head_entry[63:0];
         end
         if (drop_full)
            overflow_reg <= 1'b1;
         if (drop && (drop_reg != '1))
            drop_reg <= drop_reg + 1'b1;
      end
   end

   assign SB_RX_msg_o       = msg_reg;
   assign SB_RX_dataBus_o   = data_reg;
   assign SB_RX_msg_valid_o = valid_reg;
   assign level_o           = level_reg;
   assign overflow_o        = overflow_reg;
   assign drop_count_o      = drop_reg;
endmodule
